ref_particle_reader: RTL and testbench
======================================

// Module: ref_particle_reader
// PURPOSE
//   Read-side controller for the refx/refy/refz reference-position RAMs (single-port, registered output, 2-cycle read latency).
//   On start, fetches num_particles consecutive entries from start_addr and drives one shared address/rden to all three RAMs.
//   Delivers the results as a valid/ready stream of (x,y,z,index) to the force pipeline front end.
//   A credit-checked output FIFO absorbs in-flight reads under backpressure.
// PARAMETERS
//   DEPTH        512  words per position RAM
//   ADDR_WIDTH   9    RAM address width; clog2(DEPTH)
//   DATA_WIDTH   32   width of each coordinate word
//   READ_LATENCY 2    rden-to-q latency of the RAMs, in cycles
//   FIFO_DEPTH   4    output buffer entries; must be >= READ_LATENCY+2
// PORTS
//   clock          in   1            single clock, rising edge
//   rst            in   1            asynchronous reset, active-high
//   start          in   1            one-cycle request; ignored while busy=1
//   start_addr     in   ADDR_WIDTH   first word address
//   num_particles  in   ADDR_WIDTH+1 words to read, 0..DEPTH
//   busy           out  1            a transfer is in progress
//   done           out  1            one-cycle pulse at end of transfer
//   mem_address    out  ADDR_WIDTH   shared address to refx/refy/refz
//   mem_rden       out  1            shared read enable; wren of the RAMs is tied 0 outside this block
//   mem_q_x        in   DATA_WIDTH   refx q
//   mem_q_y        in   DATA_WIDTH   refy q
//   mem_q_z        in   DATA_WIDTH   refz q
//   out_valid      out  1            stream word valid
//   out_ready      in   1            downstream accepts when out_valid=1
//   out_x          out  DATA_WIDTH   x coordinate
//   out_y          out  DATA_WIDTH   y coordinate
//   out_z          out  DATA_WIDTH   z coordinate
//   out_index      out  ADDR_WIDTH   RAM address the word came from
//   out_last       out  1            final word of the transfer
// BEHAVIOUR
//   Reset values: busy=0, done=0, mem_rden=0, mem_address=0, out_valid=0, out_last=0.
//   Reset also clears the FIFO, the in-flight tracker and all counters. Reset mid-transfer discards all data; no done pulse.
//   FSM IDLE -> ISSUE -> DRAIN -> IDLE.
//     IDLE: start=1 latches start_addr/num_particles and sets busy=1 next cycle.
//       If count!=0 -> ISSUE; if count==0 -> DRAIN with nothing issued.
//     ISSUE: each cycle with credit (fifo_count + inflight < FIFO_DEPTH) assert mem_rden at the current address, then address+1.
//       Address wraps modulo 2^ADDR_WIDTH (0x1FF -> 0x000). After the last issue -> DRAIN.
//     DRAIN: wait until inflight==0 and the FIFO is empty.
//       Then done=1 for one cycle, busy=0 the same cycle, and go to IDLE.
//   mem_rden, mem_address: registered outputs; mem_rden is never high outside ISSUE.
//   inflight: READ_LATENCY+1 stage valid shift register fed by mem_rden.
//     Its tail writes {q_x,q_y,q_z,index,last} into the FIFO. Credit guarantees the FIFO never overflows.
//   out_*: driven from the FIFO head. A word pops when out_valid && out_ready.
//     out_* and out_last stay stable while out_valid=1 and out_ready=0.
//   Latency: start in cycle 0 -> mem_rden first high cycle 1 -> mem_q valid cycle 3 -> out_valid first high cycle 4.
//   Throughput: 1 word/cycle sustained while out_ready=1 with the default FIFO_DEPTH.
//   out_last=1 only on word num_particles-1; done follows the cycle after that word pops.
//   Simultaneous FIFO push and pop in one cycle leave fifo_count unchanged.
//   start while busy=1 is dropped, with no effect on the current transfer.
// TESTING
//   Memories preloaded with x[i]=i, y[i]=0x100+i, z[i]=0x200+i.
//   1 start_addr=0, count=8, out_ready=1 -> out_valid cycles 4..11, index 0..7, out_last at index 7, done in cycle 12.
//   2 count=6, out_ready low for cycles 4..13 -> mem_rden stops after 4 outstanding.
//     No word lost or duplicated; 6 words in order, done after the last pop.
//   3 start_addr=0x1FE, count=4 -> indices 0x1FE, 0x1FF, 0x000, 0x001; x = 0x1FE, 0x1FF, 0, 1.
//   4 count=0 -> mem_rden never high, out_valid never high, busy for 1 cycle, single done pulse.
//   5 count=512 with random out_ready -> all 512 words in order; second start mid-transfer ignored.
//   6 rst asserted at cycle 6 of a count=16 transfer -> all outputs at reset values asynchronously, no done.
//     A new start then runs cleanly from its own start_addr.

Source files
------------

// File: rtl/ref_particle_reader.sv
// Read controller for the refx/refy/refz RAMs: issues credit-limited reads
// and streams (x,y,z,index,last) words out through a small output FIFO.
module ref_particle_reader #(
  parameter int DEPTH        = 512,
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   num_particles,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  input  logic [DATA_WIDTH-1:0] mem_q_x,
  input  logic [DATA_WIDTH-1:0] mem_q_y,
  input  logic [DATA_WIDTH-1:0] mem_q_z,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_x,
  output logic [DATA_WIDTH-1:0] out_y,
  output logic [DATA_WIDTH-1:0] out_z,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last
);

  localparam int NW = ADDR_WIDTH + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;
  localparam logic [NW-1:0] MAXN = NW'(DEPTH);
  localparam logic [NW-1:0] ONE  = NW'(1);
  localparam logic [PW-1:0] PMAX = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state, state_n;
  logic [NW-1:0]         rem, rem_n, num_c;
  logic [ADDR_WIDTH-1:0] addr, addr_n, maddr_n;
  logic                  rden_n, ilast, ilast_n, done_n;

  logic [READ_LATENCY-1:0] vld, lst;
  logic [ADDR_WIDTH-1:0]   idx [READ_LATENCY];

  logic [DATA_WIDTH-1:0] fx [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fy [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fz [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fi [FIFO_DEPTH];
  logic                  fl [FIFO_DEPTH];
  logic [PW-1:0]         wptr, rptr;
  logic [CW-1:0]         fcount, inflight;
  logic                  push, pop, credit, drained;

  assign num_c = (num_particles > MAXN) ? MAXN : num_particles;
  assign push  = vld[READ_LATENCY-1];
  assign pop   = out_valid && out_ready;
  assign busy  = (state != IDLE);

  always_comb begin
    inflight = CW'(mem_rden);
    for (int i = 0; i < READ_LATENCY; i++)
      inflight = inflight + CW'(vld[i]);
  end

  // A pop this cycle frees its slot before any new read can land.
  assign credit  = (fcount + inflight) < (CW'(FIFO_DEPTH) + CW'(pop));
  assign drained = (inflight == '0) &&
                   ((fcount == '0) || (fcount == CW'(1) && pop));

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rem         <= '0;
      addr        <= '0;
      mem_rden    <= 1'b0;
      mem_address <= '0;
      ilast       <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      rem         <= rem_n;
      addr        <= addr_n;
      mem_rden    <= rden_n;
      mem_address <= maddr_n;
      ilast       <= ilast_n;
      done        <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    rem_n   = rem;
    addr_n  = addr;
    maddr_n = mem_address;
    rden_n  = 1'b0;
    ilast_n = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (num_c != '0) begin
            rden_n  = 1'b1;
            maddr_n = start_addr;
            addr_n  = start_addr + 1'b1;
            rem_n   = num_c - ONE;
            ilast_n = (num_c == ONE);
            state_n = ISSUE;
          end else begin
            state_n = DRAIN;
          end
        end
      end
      ISSUE: begin
        if (rem == '0) begin
          state_n = DRAIN;
        end else if (credit) begin
          rden_n  = 1'b1;
          maddr_n = addr;
          addr_n  = addr + 1'b1;
          rem_n   = rem - ONE;
          ilast_n = (rem == ONE);
        end
      end
      DRAIN: begin
        if (drained) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      vld <= '0;
      lst <= '0;
      for (int i = 0; i < READ_LATENCY; i++)
        idx[i] <= '0;
    end else begin
      vld[0] <= mem_rden;
      lst[0] <= ilast;
      idx[0] <= mem_address;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        lst[i] <= lst[i-1];
        idx[i] <= idx[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fx[wptr] <= mem_q_x;
      fy[wptr] <= mem_q_y;
      fz[wptr] <= mem_q_z;
      fi[wptr] <= idx[READ_LATENCY-1];
      fl[wptr] <= lst[READ_LATENCY-1];
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      fcount <= '0;
    end else begin
      if (push)
        wptr <= (wptr == PMAX) ? '0 : wptr + 1'b1;
      if (pop)
        rptr <= (rptr == PMAX) ? '0 : rptr + 1'b1;
      if (push && !pop)
        fcount <= fcount + 1'b1;
      else if (pop && !push)
        fcount <= fcount - 1'b1;
    end
  end

  assign out_valid = (fcount != '0);
  assign out_x     = fx[rptr];
  assign out_y     = fy[rptr];
  assign out_z     = fz[rptr];
  assign out_index = fi[rptr];
  assign out_last  = out_valid && fl[rptr];

endmodule

// File: tb/tb_ref_particle_reader.sv
// Directed bench for ref_particle_reader with a 2-cycle registered RAM model.
module tb_ref_particle_reader;

  logic        clock = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [8:0]  start_addr = '0;
  logic [9:0]  num_particles = '0;
  logic        busy, done, mem_rden, out_valid, out_last;
  logic        out_ready = 1;
  logic [8:0]  mem_address, out_index;
  logic [31:0] mem_q_x, mem_q_y, mem_q_z;
  logic [31:0] out_x, out_y, out_z;

  int checks = 0;
  int errors = 0;

  ref_particle_reader dut (
    .clock(clock), .rst(rst), .start(start),
    .start_addr(start_addr), .num_particles(num_particles),
    .busy(busy), .done(done),
    .mem_address(mem_address), .mem_rden(mem_rden),
    .mem_q_x(mem_q_x), .mem_q_y(mem_q_y), .mem_q_z(mem_q_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .out_index(out_index), .out_last(out_last)
  );

  always #5 clock = ~clock;

  // RAM model: address registered, then data registered
  logic [8:0] a1;
  logic       r1;
  always @(posedge clock) begin
    r1 <= mem_rden;
    if (mem_rden) a1 <= mem_address;
    if (r1) begin
      mem_q_x <= {23'd0, a1};
      mem_q_y <= 32'h100 + {23'd0, a1};
      mem_q_z <= 32'h200 + {23'd0, a1};
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int n_words, n_rden, first_v, last_v;
  int done_cnt, done_rel, max_out, busy_cyc;

  // mode 0: ready=1, 1: ready low rel 4..13, 2: random + second start
  task automatic run(input logic [8:0] a, input logic [9:0] n,
                     input int mode, input int budget);
    logic [8:0] ei;
    n_words = 0; n_rden = 0; first_v = -1; last_v = -1;
    done_cnt = 0; done_rel = -1; max_out = 0; busy_cyc = 0;
    @(posedge clock); #1;
    for (int rel = 0; rel < budget; rel++) begin
      if (done_rel >= 0 && rel >= done_rel + 3) break;
      start = (rel == 0) || (mode == 2 && rel == 20);
      start_addr = (rel == 0) ? a : 9'h055;
      num_particles = (rel == 0) ? n : 10'd3;
      if (mode == 1) out_ready = !(rel >= 4 && rel <= 13);
      else if (mode == 2) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = 1'b1;
      @(negedge clock);
      if (mem_rden) n_rden++;
      if (n_rden - n_words > max_out) max_out = n_rden - n_words;
      if (busy) busy_cyc++;
      if (out_valid && out_ready) begin
        ei = a + n_words[8:0];
        check("index", 64'(out_index), 64'(ei));
        check("x", 64'(out_x), 64'(ei));
        check("yz", {out_y, out_z},
              {32'h100 + 32'(ei), 32'h200 + 32'(ei)});
        check("last", 64'(out_last), 64'(n_words == int'(n) - 1));
        if (first_v < 0) first_v = rel;
        last_v = rel;
        n_words++;
      end
      if (done) begin
        done_cnt++;
        done_rel = rel;
      end
      @(posedge clock); #1;
    end
    start = 0;
    out_ready = 1;
    check("done_once", 64'(done_cnt), 64'd1);
    check("word_count", 64'(n_words), 64'(n));
  endtask

  initial begin
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rden", 64'(mem_rden), 64'd0);
    check("rst_addr", 64'(mem_address), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    @(negedge clock);
    rst = 0;

    run(9'h000, 10'd8, 0, 200);
    check("t1_first", 64'(first_v), 64'd4);
    check("t1_lastv", 64'(last_v), 64'd11);
    check("t1_done", 64'(done_rel), 64'd12);
    check("t1_rden", 64'(n_rden), 64'd8);

    run(9'h000, 10'd6, 1, 200);
    check("t2_maxout", 64'(max_out), 64'd4);
    check("t2_done", 64'(done_rel), 64'(last_v + 1));
    check("t2_rden", 64'(n_rden), 64'd6);

    run(9'h1FE, 10'd4, 0, 200);
    check("t3_done", 64'(done_rel), 64'd8);

    run(9'h033, 10'd0, 0, 50);
    check("t4_rden", 64'(n_rden), 64'd0);
    check("t4_first", 64'(first_v), 64'hFFFF_FFFF_FFFF_FFFF);
    check("t4_busy", 64'(busy_cyc), 64'd1);
    check("t4_done", 64'(done_rel), 64'd2);

    run(9'h000, 10'd512, 2, 4000);
    check("t5_rden", 64'(n_rden), 64'd512);
    check("t5_idle", 64'(busy), 64'd0);

    @(posedge clock); #1;
    start = 1; start_addr = 9'h010; num_particles = 10'd16;
    @(posedge clock); #1;
    start = 0;
    repeat (5) @(posedge clock);
    #2 rst = 1;
    #1;
    check("r_busy", 64'(busy), 64'd0);
    check("r_done", 64'(done), 64'd0);
    check("r_rden", 64'(mem_rden), 64'd0);
    check("r_addr", 64'(mem_address), 64'd0);
    check("r_valid", 64'(out_valid), 64'd0);
    check("r_last", 64'(out_last), 64'd0);
    repeat (2) @(posedge clock);
    #2 rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("r_quiet", {62'd0, done, out_valid}, 64'd0);
    end
    run(9'h040, 10'd5, 0, 200);
    check("r_first", 64'(first_v), 64'd4);
    check("r_done2", 64'(done_rel), 64'd9);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
